// File: rtl/lsu_pkg.sv
// Shared encodings, state type and alignment helper for the load/store unit.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      default:   is_misaligned = |offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane
// merge into a previously read word for read-modify-write stores.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  localparam int unsigned BYTE_W = 32 / LANES;
  localparam int unsigned HALF_W = 2 * BYTE_W;

  logic [4:0]        byte_pos;
  logic [4:0]        half_pos;
  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Little-endian: lane 0 occupies bits [7:0].
  assign byte_pos = {offset, 3'b000};
  assign half_pos = {offset[1], 4'b0000};
  assign byte_sel = word[byte_pos +: BYTE_W];
  assign half_sel = word[half_pos +: HALF_W];

  always_comb begin
    load_data = word;
    merged    = store_data;
    case (size)
      SIZE_BYTE: begin
        load_data = {{(32-BYTE_W){sign_ext & byte_sel[BYTE_W-1]}}, byte_sel};
        merged    = word;
        merged[byte_pos +: BYTE_W] = store_data[BYTE_W-1:0];
      end
      SIZE_HALF: begin
        load_data = {{(32-HALF_W){sign_ext & half_sel[HALF_W-1]}}, half_sel};
        merged    = word;
        merged[half_pos +: HALF_W] = store_data[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit driving a word-wide dataMemory port.
// Define LSU_SUBWORD_EN to build byte/half accesses and read-modify-write stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] readData
);

  lsu_state_e        state, state_d;
  logic              ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [DATA_W-1:0] resp_rdata_d, write_data_d;
  logic [ADDR_W-1:0] address_d;
  logic              accept_c, misalign_c, word_store_c, rmw_c;
  logic [DATA_W-1:0] load_c, merge_c;

  assign accept_c = req_valid & req_ready;

`ifdef LSU_SUBWORD_EN
  logic              write_q, sign_q;
  logic [1:0]        size_q, off_q;
  logic [DATA_W-1:0] wdata_q;

  // Request fields needed after the accept edge by the lane logic.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      wdata_q <= '0;
    end else if (accept_c) begin
      write_q <= req_write;
      sign_q  <= req_signed;
      size_q  <= req_size;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
  end

  lsu_lane_unit u_lane (
    .word       (readData),
    .offset     (off_q),
    .size       (size_q),
    .sign_ext   (sign_q),
    .store_data (wdata_q),
    .load_data  (load_c),
    .merged     (merge_c)
  );

  assign misalign_c   = is_misaligned(req_size, req_addr[1:0]);
  assign word_store_c = req_write & req_size[1];
  assign rmw_c        = write_q;
`else
  logic cfg_unused;

  assign cfg_unused   = ^{req_size, req_signed};
  assign misalign_c   = |req_addr[1:0];
  assign word_store_c = req_write;
  assign rmw_c        = 1'b0;
  assign load_c       = readData;
  assign merge_c      = readData;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state;
    resp_valid_d = resp_valid;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = address;
    write_data_d = writeData;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          address_d = {req_addr[ADDR_W-1:2], 2'b00};
          if (misalign_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (word_store_c) begin
            state_d      = ST_WRITE;
            mem_write_d  = 1'b1;
            write_data_d = req_wdata;
          end else begin
            state_d    = ST_READ;
            mem_read_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rmw_c) begin
          state_d      = ST_WRITE;
          mem_write_d  = 1'b1;
          write_data_d = merge_c;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_c;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Async reset clears memRead/memWrite at once, aborting any pending write.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      address    <= '0;
      writeData  <= '0;
    end else begin
      state      <= state_d;
      req_ready  <= ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      memRead    <= mem_read_d;
      memWrite   <= mem_write_d;
      address    <= address_d;
      writeData  <= write_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-wide behavioural memory.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;

  logic [31:0] mem [0:63];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] shadow20 = 32'h0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [$];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .address    (address),
    .writeData  (writeData),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .readData   (readData)
  );

  always #5 CLK = ~CLK;

  assign readData = mem[address[7:2]];

  always @(posedge CLK) begin
    if (memWrite) begin
      mem[address[7:2]] <= writeData;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= address;
      last_wdata <= writeData;
    end
    if (memRead) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge CLK) begin
    if (reset) begin
      checks++;
      if (memRead && memWrite) begin
        errors++;
        $display("FAIL rd_wr_exclusive: memRead=%b memWrite=%b, required not both 1", memRead, memWrite);
      end
    end
  end

  function automatic logic tb_misal(input logic [1:0] sz, input logic [31:0] a);
    if (!SUBWORD || sz[1]) return a[1:0] != 2'b00;
    if (sz == 2'b01) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] tb_load(input logic [31:0] word, input logic [1:0] sz,
                                          input logic sg, input logic [31:0] a);
    logic [31:0] sh;
    if (!SUBWORD || sz[1]) return word;
    sh = word >> {a[1:0], 3'b000};
    if (sz == 2'b00) return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    sh = word >> {a[1], 4'b0000};
    return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m;
    if (!SUBWORD || sz[1]) return d;
    m = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (word & ~(m << {a[1:0], 3'b000})) | ((d & m) << {a[1:0], 3'b000});
  endfunction

  function automatic exp_t mk_exp(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] word);
    exp_t ex;
    ex.err   = tb_misal(sz, a);
    ex.rdata = (w || ex.err) ? 32'h0 : tb_load(word, sz, sg, a);
    if (ex.err) ex.lat = 8'd1;
    else if (SUBWORD && w && !sz[1]) ex.lat = 8'd3;
    else ex.lat = 8'd2;
    return ex;
  endfunction

  // Present a request at a negedge; return at the negedge after the accept edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  // Latency counts cycles after the accept edge up to the first resp_valid cycle.
  task automatic get_resp(output logic [31:0] rd, output logic e, output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    rd = resp_rdata;
    e  = resp_err;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({req_ready, resp_valid, resp_err, memRead, memWrite} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: rdy/vld/err/rd/wr=%b required 10000",
               {req_ready, resp_valid, resp_err, memRead, memWrite});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 00000000", resp_rdata);
    end
    checks++;
    if (address !== 32'h0) begin
      errors++; $display("FAIL reset_address: got %h required 00000000", address);
    end
    checks++;
    if (writeData !== 32'h0) begin
      errors++; $display("FAIL reset_wdata: got %h required 00000000", writeData);
    end
  endtask

  task automatic test_word_store_load();
    exp_t ex; logic [31:0] rd; logic e; int lat; int w0;
    w0 = wr_cnt;
    exp_q.push_back(mk_exp(1'b1, 2'b10, 1'b0, 32'h18, 32'h0));
    send(1'b1, 2'b10, 1'b0, 32'h18, 32'hE000_0000);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL word_store_resp: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    checks++;
    if ({32'(wr_cnt - w0), last_waddr, last_wdata} !== {32'd1, 32'h18, 32'hE000_0000}) begin
      errors++;
      $display("FAIL word_store_mem: writes=%0d addr=%h data=%h required 1 00000018 e0000000",
               wr_cnt - w0, last_waddr, last_wdata);
    end
    exp_q.push_back(mk_exp(1'b0, 2'b10, 1'b0, 32'h18, 32'hE000_0000));
    send(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL word_load_resp: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
  endtask

  task automatic test_sign_ext();
    exp_t ex; logic [31:0] rd; logic e; int lat;
    logic [1:0]  sz_t [5];
    logic        sg_t [5];
    logic [31:0] a_t  [5];
    sz_t = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    sg_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    a_t  = '{32'h19, 32'h19, 32'h1A, 32'h18, 32'h18};
    exp_q.push_back(mk_exp(1'b1, 2'b10, 1'b0, 32'h18, 32'h0));
    send(1'b1, 2'b10, 1'b0, 32'h18, 32'hFFFF_80AA);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL sign_setup: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk_exp(1'b0, sz_t[i], sg_t[i], a_t[i], 32'hFFFF_80AA));
      send(1'b0, sz_t[i], sg_t[i], a_t[i], 32'h0);
      get_resp(rd, e, lat); ex = exp_q.pop_front();
      checks++;
      if ({rd, e, 8'(lat)} !== ex) begin
        errors++;
        $display("FAIL sub_load_%0d: rdata=%h err=%b lat=%0d required %h %b %0d",
                 i, rd, e, lat, ex.rdata, ex.err, ex.lat);
      end
    end
  endtask

  task automatic test_rmw();
    exp_t ex; logic [31:0] rd; logic e; int lat; int w0; int r0; logic bad;
    exp_q.push_back(mk_exp(1'b1, 2'b10, 1'b0, 32'h20, 32'h0));
    send(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL rmw_setup: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    w0 = wr_cnt; r0 = rd_cnt;
    bad = tb_misal(2'b00, 32'h22);
    shadow20 = bad ? 32'hAAAA_AAAA : tb_merge(32'hAAAA_AAAA, 2'b00, 32'h22, 32'h55);
    exp_q.push_back(mk_exp(1'b1, 2'b00, 1'b0, 32'h22, 32'h0));
    send(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_0055);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL rmw_resp: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    checks++;
    if ({32'(rd_cnt - r0), 32'(wr_cnt - w0), last_wdata} !== {32'(!bad), 32'(!bad), shadow20}) begin
      errors++;
      $display("FAIL rmw_mem: reads=%0d writes=%0d wdata=%h required %0d %0d %h",
               rd_cnt - r0, wr_cnt - w0, last_wdata, !bad, !bad, shadow20);
    end
    exp_q.push_back(mk_exp(1'b0, 2'b10, 1'b0, 32'h20, shadow20));
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL rmw_readback: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
  endtask

  task automatic test_misaligned();
    exp_t ex; logic [31:0] rd; logic e; int lat; int w0; int r0;
    logic        w_t  [3];
    logic [1:0]  sz_t [3];
    logic [31:0] a_t  [3];
    w_t  = '{1'b0, 1'b0, 1'b1};
    sz_t = '{2'b10, 2'b01, 2'b10};
    a_t  = '{32'h06, 32'h03, 32'h05};
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_exp(w_t[i], sz_t[i], 1'b1, a_t[i], 32'h0));
      send(w_t[i], sz_t[i], 1'b1, a_t[i], 32'h1234_5678);
      get_resp(rd, e, lat); ex = exp_q.pop_front();
      checks++;
      if ({rd, e, 8'(lat)} !== ex) begin
        errors++;
        $display("FAIL misalign_%0d: rdata=%h err=%b lat=%0d required %h %b %0d",
                 i, rd, e, lat, ex.rdata, ex.err, ex.lat);
      end
    end
    @(negedge CLK);
    checks++;
    if ({32'(rd_cnt - r0), 32'(wr_cnt - w0)} !== 64'h0) begin
      errors++;
      $display("FAIL misalign_no_mem: reads=%0d writes=%0d required 0 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    exp_t ex; logic [31:0] rd; logic e; int lat;
    resp_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 2'b10, 1'b0, 32'h18, 32'hFFFF_80AA));
    send(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL bp_first: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, ex.rdata}) begin
        errors++;
        $display("FAIL bp_stall_%0d: vld=%b rdy=%b rdata=%h required 1 0 %h",
                 i, resp_valid, req_ready, resp_rdata, ex.rdata);
      end
    end
    resp_ready = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 2'b10, 1'b0, 32'h20, shadow20));
    @(negedge CLK);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
    @(negedge CLK);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: rdy=%b required 0 (accepted)", req_ready);
    end
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL bp_second: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
  endtask

  task automatic test_reset_mid_write();
    exp_t ex; logic [31:0] rd; logic e; int lat; int w0;
    exp_q.push_back(mk_exp(1'b1, 2'b10, 1'b0, 32'h30, 32'h0));
    send(1'b1, 2'b10, 1'b0, 32'h30, 32'h1234_5678);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL rst_setup: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
    w0 = wr_cnt;
    send(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF);
    checks++;
    if (memWrite !== 1'b1) begin
      errors++; $display("FAIL rst_in_write: memWrite=%b required 1", memWrite);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({memWrite, memRead} !== 2'b00) begin
      errors++; $display("FAIL rst_async_drop: wr/rd=%b required 00", {memWrite, memRead});
    end
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({req_ready, resp_valid, 32'(wr_cnt - w0)} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rst_after: rdy=%b vld=%b writes=%0d required 1 0 0",
               req_ready, resp_valid, wr_cnt - w0);
    end
    exp_q.push_back(mk_exp(1'b0, 2'b10, 1'b0, 32'h30, 32'h1234_5678));
    send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    get_resp(rd, e, lat); ex = exp_q.pop_front();
    checks++;
    if ({rd, e, 8'(lat)} !== ex) begin
      errors++;
      $display("FAIL rst_mem_kept: rdata=%h err=%b lat=%0d required %h %b %0d",
               rd, e, lat, ex.rdata, ex.err, ex.lat);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_sign_ext();
    test_rmw();
    test_misaligned();
    test_backpressure();
    test_reset_mid_write();
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts load/store requests from the CPU MEM stage over a valid/ready handshake and drives `address`, `writeData`, `memWrite`, `memRead` into `dataMemory`, sampling `readData`. Performs byte/halfword extraction with sign/zero extension on loads. Subword stores are done as read-modify-write, since `dataMemory` only writes whole words. Detects misaligned accesses and returns an error response instead of touching memory.

## Interface
- `ADDR_W`, default 32: width of the CPU byte address and the memory `address`.
- `DATA_W`, default 32: word width; fixed at 32, and lane logic assumes 4 byte lanes.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_signed` in 1: sign-extend subword loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: CPU accepts the response.
- `resp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access.
- `address` out ADDR_W: to `dataMemory`; always word-aligned (`req_addr` with bits [1:0] forced to 0).
- `writeData` out DATA_W: to `dataMemory`.
- `memWrite` out 1: to `dataMemory`; memory writes on the `CLK` edge while high.
- `memRead` out 1: to `dataMemory`; `readData` is valid combinationally in the same cycle.
- `readData` in DATA_W: from `dataMemory`.

## Operation
- States and transitions:
  - IDLE goes to READ for a load or a subword store.
  - IDLE goes to WRITE for a word store.
  - IDLE goes to RESP for a misaligned request.
  - READ goes to RESP for a load, or to WRITE for a subword store.
  - WRITE goes to RESP.
  - RESP goes to IDLE.
- `req_ready` = (state == IDLE). A request is accepted on an edge where `req_valid` and `req_ready` are both high. All request fields are latched at that edge.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0. Response has `resp_err` = 1 and `resp_rdata` = 0, with no `memRead`/`memWrite` pulse.
- READ: `memRead` = 1 and `address` is driven. `readData` is captured into a word buffer at the edge.
- Load extraction: lane = addr[1:0] for bytes, addr[1] for halves; little-endian, so byte 0 is bits [7:0]. The selected lane is zero- or sign-extended per `req_signed`. Word loads pass through unchanged.
- WRITE: `memWrite` = 1 for exactly one cycle.
  - Word store: `writeData` = `req_wdata`.
  - Subword store: `writeData` = the buffered word with the target lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`. All other lanes are unchanged.
- RESP: `resp_valid` = 1 and is held, with data stable, until `resp_ready`. Then the unit returns to IDLE.
- `memRead` and `memWrite` are never high together. Both are 0 outside READ and WRITE.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `memRead` = 0, `memWrite` = 0, `address` = 0, `writeData` = 0.
- Latency from the accept edge to the first `resp_valid` cycle:
  - Load: 2 cycles (READ, then RESP).
  - Word store: 2 cycles (WRITE, then RESP).
  - Subword store: 3 cycles (READ, WRITE, RESP).
  - Misaligned: 1 cycle.
- If `resp_ready` is high in the first RESP cycle, the unit is back in IDLE on the next cycle. Best-case throughput is therefore one load per 3 cycles.
- `resp_ready` held low stalls the unit in RESP indefinitely; no new request is accepted.
- Reset asserted mid-operation: `memWrite` and `memRead` drop to 0 immediately (asynchronously). The pending request is discarded with no response. If a WRITE cycle is interrupted before its edge, the memory word is not modified.
- `req_valid` outside IDLE is ignored; the CPU holds it until `req_ready`.

## Configuration
- `LSU_SUBWORD_EN` defined: byte/half loads and stores, sign extension, and read-modify-write are supported as above.
- `LSU_SUBWORD_EN` undefined:
  - `req_size` and `req_signed` are ignored; every access is a word access.
  - addr[1:0] != 0 gives `resp_err`.
  - Stores always go IDLE to WRITE; the READ-before-WRITE path and lane logic are not built.

## Structure
- Package `lsu_pkg`:
  - Size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - State enum covering IDLE, READ, WRITE and RESP.
  - Constant `LANES` = 4.
- Sub-module `lsu_lane_unit`: combinational. Inputs are word, offset, size, signed and store data. Outputs are the extracted/extended load data and the merged store word. It is instantiated only under `LSU_SUBWORD_EN`.

## Test plan
- Word store then load: store `req_addr` = 0x18, data 0xE0000000, then load 0x18 word. Expect exactly one `memWrite` cycle with `address` = 0x18, then `resp_rdata` = 0xE0000000. Load latency is 2 cycles.
- Signed/unsigned byte load: memory[0x18] = 0xFFFF80AA.
  - Load byte at 0x19, signed: expect 0xFFFFFF80.
  - Load byte at 0x19, unsigned: expect 0x00000080.
  - Load half at 0x1A, signed: expect 0xFFFFFFFF.
- Subword store read-modify-write: memory[0x20] = 0xAAAAAAAA, store byte 0x55 at 0x22.
  - Expect READ then WRITE with `writeData` = 0xAA55AAAA.
  - Expect `resp_valid` 3 cycles after the accept edge.
- Misaligned: word load at 0x06 gives `resp_err` = 1 and `resp_rdata` = 0 one cycle after accept, with no `memRead` or `memWrite` pulse.
- Backpressure: hold `resp_ready` = 0 for 5 cycles.
  - `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0.
  - A new `req_valid` during this time is not accepted.
  - The request is accepted 1 cycle after `resp_ready` rises.
- Reset mid-WRITE: assert `reset` low during the WRITE cycle, before the edge. Expect `memWrite` to fall immediately, memory unchanged, no response, and `req_ready` = 1 after reset.
